// File: rtl/screen_sequencer_if.sv
// Signal bundle between the SkyHop screen sequencer and the VGA/game pipeline.
interface screen_sequencer_if;
  logic       vblnk;
  logic       start_btn;
  logic       player_dead;
  logic       start_en;
  logic       countdown_en;
  logic       game_en;
  logic       over_en;
  logic       game_rst;
  logic [1:0] countdown_val;
  logic [1:0] state;

  modport slave (
    input  vblnk, start_btn, player_dead,
    output start_en, countdown_en, game_en, over_en, game_rst, countdown_val, state
  );

  modport master (
    output vblnk, start_btn, player_dead,
    input  start_en, countdown_en, game_en, over_en, game_rst, countdown_val, state
  );
endinterface

// File: rtl/screen_sequencer.sv
// SkyHop game-flow controller: START -> COUNTDOWN -> GAME -> OVER, switching only on frame ticks.
module screen_sequencer #(
  parameter int DIGIT_FRAMES     = 60,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst,
  screen_sequencer_if.slave  bus
);
  localparam int FW = $clog2(DIGIT_FRAMES) + 1;
  localparam int HW = $clog2(OVER_HOLD_FRAMES) + 1;
  localparam logic [FW-1:0] FRAME_LOAD = FW'(DIGIT_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [FW-1:0] FRAME_ZERO = FW'(0);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(OVER_HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO  = HW'(0);

  typedef enum logic [1:0] {
    ST_START     = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_GAME      = 2'b10,
    ST_OVER      = 2'b11
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    digit_r, digit_s;
  logic [FW-1:0] frame_cnt_r, frame_cnt_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic          press_pending_r, press_pending_s;
  logic          dead_pending_r, dead_pending_s;
  logic          game_rst_s;
  logic          vblnk_d_r, btn_meta_r, btn_sync_r, btn_prev_r;
  logic          start_en_r, countdown_en_r, game_en_r, over_en_r, game_rst_r;
  logic [1:0]    countdown_val_r;
  logic          tick_s, press_s, press_seen_s, dead_seen_s;

  assign tick_s       = bus.vblnk & ~vblnk_d_r;
  assign press_s      = btn_sync_r & ~btn_prev_r;
  // A press or death arriving in the tick cycle itself still counts for that tick.
  assign press_seen_s = press_pending_r | press_s;
  assign dead_seen_s  = dead_pending_r | bus.player_dead;

  // Frame-edge register and button synchroniser with edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d_r  <= 1'b0;
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      btn_prev_r <= 1'b0;
    end else begin
      vblnk_d_r  <= bus.vblnk;
      btn_meta_r <= bus.start_btn;
      btn_sync_r <= btn_meta_r;
      btn_prev_r <= btn_sync_r;
    end
  end

  // Next-state, counter and pending-flag logic.
  always_comb begin
    state_s     = state_r;
    digit_s     = digit_r;
    frame_cnt_s = frame_cnt_r;
    hold_cnt_s  = hold_cnt_r;
    game_rst_s  = 1'b0;
    if (tick_s) begin
      press_pending_s = 1'b0;
      case (state_r)
        ST_START: begin
          if (press_seen_s) begin
            state_s     = ST_COUNTDOWN;
            digit_s     = 2'd3;
            frame_cnt_s = FRAME_LOAD;
            game_rst_s  = 1'b1;
          end else begin
            state_s = ST_START;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_cnt_r != FRAME_ZERO) begin
            frame_cnt_s = frame_cnt_r - FRAME_ONE;
          end else if (digit_r > 2'd1) begin
            digit_s     = digit_r - 2'd1;
            frame_cnt_s = FRAME_LOAD;
          end else begin
            state_s = ST_GAME;
          end
        end
        ST_GAME: begin
          if (dead_seen_s) begin
            state_s    = ST_OVER;
            hold_cnt_s = HOLD_LOAD;
          end else begin
            state_s = ST_GAME;
          end
        end
        ST_OVER: begin
          if (hold_cnt_r != HOLD_ZERO) begin
            hold_cnt_s = hold_cnt_r - HOLD_ONE;
          end else if (press_seen_s) begin
            state_s = ST_START;
          end else begin
            state_s = ST_OVER;
          end
        end
        default: state_s = ST_START;
      endcase
    end else begin
      press_pending_s = press_seen_s;
    end
    if ((state_r == ST_GAME) && (state_s == ST_GAME)) begin
      dead_pending_s = dead_seen_s;
    end else begin
      dead_pending_s = 1'b0;
    end
  end

  // State, counters and registered overlay outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_START;
      digit_r         <= 2'd0;
      frame_cnt_r     <= FRAME_ZERO;
      hold_cnt_r      <= HOLD_ZERO;
      press_pending_r <= 1'b0;
      dead_pending_r  <= 1'b0;
      start_en_r      <= 1'b1;
      countdown_en_r  <= 1'b0;
      game_en_r       <= 1'b0;
      over_en_r       <= 1'b0;
      game_rst_r      <= 1'b0;
      countdown_val_r <= 2'd0;
    end else begin
      state_r         <= state_s;
      digit_r         <= digit_s;
      frame_cnt_r     <= frame_cnt_s;
      hold_cnt_r      <= hold_cnt_s;
      press_pending_r <= press_pending_s;
      dead_pending_r  <= dead_pending_s;
      start_en_r      <= (state_s == ST_START);
      countdown_en_r  <= (state_s == ST_COUNTDOWN);
      game_en_r       <= (state_s == ST_GAME);
      over_en_r       <= (state_s == ST_OVER);
      game_rst_r      <= game_rst_s;
      countdown_val_r <= (state_s == ST_COUNTDOWN) ? digit_s : 2'd0;
    end
  end

  assign bus.start_en      = start_en_r;
  assign bus.countdown_en  = countdown_en_r;
  assign bus.game_en       = game_en_r;
  assign bus.over_en       = over_en_r;
  assign bus.game_rst      = game_rst_r;
  assign bus.countdown_val = countdown_val_r;
  assign bus.state         = state_r;
endmodule
